cbus_arbiter_n: RTL and testbench
=================================

# cbus_arbiter_n

N-master arbiter for the simplified burst AXI cache bus (`cbus_req_t` / `cbus_resp_t`). It sits between the per-cache `cbus` masters (I-cache, D-cache, uncached path, future PTW) and the single `cbus` port towards the AXI bridge. It grants one whole burst at a time and holds the grant until the last beat. Round-robin or fixed-priority selection is chosen by parameter.

## Interface
- `NUM_MASTERS`, default 2: number of requesting `cbus` masters; legal range 1..16.
- `MODE`, default 0: 0 = round-robin, 1 = fixed priority (index 0 highest).
- `IDX_W`, default `NUM_MASTERS>1 ? $clog2(NUM_MASTERS) : 1`: width of the grant index; derived, never overridden.

Ports:
- `clk`  in  1  system clock; all state on the rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `ireqs`  in  `cbus_req_t [NUM_MASTERS]`  master requests.
- `iresps`  out  `cbus_resp_t [NUM_MASTERS]`  per-master responses.
- `oreq`  out  `cbus_req_t`  request to the AXI bridge.
- `oresp`  in  `cbus_resp_t`  response from the AXI bridge.
- `grant_valid`  out  1  a burst is currently owned (state BUSY).
- `grant_idx`  out  `IDX_W`  index of the owning master; meaningful only when `grant_valid`.

## Operation
- State machine:
  - Two states, IDLE and BUSY.
  - Registers: `state`, `grant_idx`, `rr_ptr` (IDX_W bits).
- IDLE:
  - `oreq` is all-zero (`valid=0`).
  - Every `iresps[i]` is all-zero.
  - If any `ireqs[i].valid`, the winner is selected combinationally. Next cycle: `grant_idx <= winner`, `state <= BUSY`.
- Winner selection:
  - MODE 0: the first valid index searching upward from `rr_ptr`, wrapping from `NUM_MASTERS-1` to 0. Non-power-of-two counts never select an index ≥ `NUM_MASTERS`.
  - MODE 1: the lowest valid index.
- BUSY:
  - `oreq = ireqs[grant_idx]`, passed through unregistered.
  - `iresps[grant_idx] = oresp`. All other `iresps` are zero.
  - Non-granted masters keep waiting and must hold their requests stable.
- End of burst:
  - Trigger: in BUSY, `oresp.ready && oresp.last`.
  - Next cycle: `state <= IDLE` and `rr_ptr <= (grant_idx == NUM_MASTERS-1) ? 0 : grant_idx+1`.
  - `rr_ptr` is updated in MODE 1 as well but unused there.
- Grant lock:
  - The grant is never revoked before `last`, even if the owner drops `valid` mid-burst (protocol violation).
  - In that case `oreq.valid` follows the owner, i.e. goes 0, and the arbiter stays BUSY.
- `oresp` handling: `oresp.ready`/`last` in IDLE are ignored and not forwarded.
- `NUM_MASTERS == 1`: same FSM; `grant_idx` is constantly 0.

## Timing
- Reset values (asserted asynchronously, on `resetn` low):
  - `state = IDLE`, `grant_idx = 0`, `rr_ptr = 0`.
  - `grant_valid = 0`, `oreq = '0`, all `iresps = '0`.
- Reset mid-burst: drops the grant immediately. The bridge must be reset together with the arbiter.
- Grant latency:
  - Request valid in cycle t (state IDLE) → `oreq.valid` from cycle t+1.
  - The first beat can return at t+1 at the earliest, if the bridge is combinationally ready.
- Release:
  - The last beat is accepted in cycle t → IDLE at t+1 → the next owner drives `oreq` at t+2.
  - There is exactly one dead cycle between back-to-back bursts.
- Response forwarding: combinational, zero-cycle latency from `oresp` to `iresps[grant_idx]`.
- Simultaneous events:
  - A new request arriving in the same cycle as `last` is not considered until the IDLE cycle.
  - Selection then uses the already-advanced `rr_ptr`.
- No combinational path from `ireqs[*].valid` to `oreq` while in IDLE; the grant is always registered first.

## Test plan
- Single request:
  - Stimulus: NUM_MASTERS=2, MODE=0; master 1 issues a read, `len=MLEN4`, `addr=64'h8000_0040`. Bridge returns 4 beats `64'h11..64'h44`, `last` on the 4th.
  - Required: `oreq.addr=64'h8000_0040` from the cycle after `valid`; `iresps[1]` carries the 4 beats; `iresps[0]` stays zero; IDLE after the 4th beat.
- Round-robin fairness:
  - Stimulus: NUM_MASTERS=3, MODE=0; all three request `MLEN1` bursts continuously.
  - Required: grant order 0,1,2,0,1,2; one IDLE cycle between grants.
- Fixed priority:
  - Stimulus: MODE=1; masters 0 and 2 request continuously.
  - Required: master 0 is granted every time; master 2 is never granted while master 0 stays valid.
- Lock across burst:
  - Stimulus: master 0 owns a `MLEN16` write; master 1 raises `valid` at beat 3.
  - Required: `grant_idx` stays 0 for all 16 beats; master 1 is granted at last+2.
- Wrap-around:
  - Stimulus: NUM_MASTERS=3, `rr_ptr` at 2 after master 1 finishes; only master 0 is valid.
  - Required: master 0 is granted; `rr_ptr` becomes 1 after its `last`.
- Reset mid-burst:
  - Stimulus: drive `resetn` low at beat 2 of an 8-beat read.
  - Required: same cycle, `oreq.valid=0`, `grant_valid=0`, all `iresps` zero; after release, a fresh request gets a grant 1 cycle later with `rr_ptr=0`.

Source files
------------

// File: rtl/cbus_arbiter_n.sv
// cbus_pkg: request/response types of the simplified burst cache bus.
// cbus_arbiter_n: N-master arbiter that grants one whole burst at a time
// and holds the grant until the bridge returns the last beat.
//
// Handshake: a master's request is presented while ireqs[i].valid is high and
// must be held stable until its burst ends. Each beat is transferred in a
// cycle where oresp.ready is high; the burst ends on the beat that also has
// oresp.last high. Only the granted master sees oresp, and only while BUSY.
package cbus_pkg;

    // Burst length encoded as beats-1, AXI style.
    typedef enum logic [3:0] {
        MLEN1  = 4'd0,
        MLEN2  = 4'd1,
        MLEN4  = 4'd3,
        MLEN8  = 4'd7,
        MLEN16 = 4'd15
    } cbus_len_t;

    typedef struct packed {
        logic        valid;
        logic        is_write;
        logic [63:0] addr;
        logic [2:0]  size;
        cbus_len_t   len;
        logic [7:0]  strobe;
        logic [63:0] data;
    } cbus_req_t;

    typedef struct packed {
        logic        ready;
        logic        last;
        logic [63:0] data;
    } cbus_resp_t;

endpackage

module cbus_arbiter_n
    import cbus_pkg::*;
#(
    parameter int NUM_MASTERS = 2,
    parameter int MODE        = 0,
    parameter int IDX_W       = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1
) (
    input  logic             clk,
    input  logic             resetn,
    input  cbus_req_t        ireqs  [NUM_MASTERS],
    output cbus_resp_t       iresps [NUM_MASTERS],
    output cbus_req_t        oreq,
    input  cbus_resp_t       oresp,
    output logic             grant_valid,
    output logic [IDX_W-1:0] grant_idx
);

    // grant_valid is the externally visible copy of the FSM state (BUSY).
    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] grant_idx_q, grant_idx_d;
    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;

    logic             any_valid;
    logic [IDX_W-1:0] winner;
    int               cand;
    logic             burst_end;

    // Winner search: round-robin starts at rr_ptr and wraps at NUM_MASTERS-1,
    // fixed priority simply takes the lowest valid index. The candidate index
    // is always reduced below NUM_MASTERS, so odd master counts never select
    // a non-existent master.
    always_comb begin
        any_valid = 1'b0;
        winner    = '0;
        cand      = 0;
        for (int k = 0; k < NUM_MASTERS; k++) begin
            if (MODE == 1) begin
                cand = k;
            end else begin
                cand = int'(rr_ptr_q) + k;
                if (cand >= NUM_MASTERS) begin
                    cand = cand - NUM_MASTERS;
                end
            end
            for (int i = 0; i < NUM_MASTERS; i++) begin
                if (!any_valid && (i == cand) && ireqs[i].valid) begin
                    any_valid = 1'b1;
                    winner    = IDX_W'(i);
                end
            end
        end
    end

    // The burst ends on the beat the bridge accepts with last set.
    assign burst_end = oresp.ready && oresp.last;

    // Next-state logic: grant is registered out of IDLE and only released by
    // the last beat; a master dropping valid mid-burst does not release it.
    always_comb begin
        state_d     = state_q;
        grant_idx_d = grant_idx_q;
        rr_ptr_d    = rr_ptr_q;
        case (state_q)
            IDLE: begin
                if (any_valid) begin
                    grant_idx_d = winner;
                    state_d     = BUSY;
                end
            end
            BUSY: begin
                if (burst_end) begin
                    state_d  = IDLE;
                    rr_ptr_d = (grant_idx_q == IDX_W'(NUM_MASTERS - 1)) ? '0
                                                                         : grant_idx_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers, cleared asynchronously so a reset drops the grant at once.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= IDLE;
            grant_idx_q <= '0;
            rr_ptr_q    <= '0;
        end else begin
            state_q     <= state_d;
            grant_idx_q <= grant_idx_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    // Datapath mux: owner's request straight to the bridge and the bridge
    // response straight back to the owner; everything zero while IDLE so
    // requests never reach oreq before the grant is registered.
    always_comb begin
        oreq = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            iresps[i] = '0;
        end
        if (state_q == BUSY) begin
            for (int i = 0; i < NUM_MASTERS; i++) begin
                if (grant_idx_q == IDX_W'(i)) begin
                    oreq      = ireqs[i];
                    iresps[i] = oresp;
                end
            end
        end
    end

    assign grant_valid = (state_q == BUSY);
    assign grant_idx   = grant_idx_q;

    // The owner index can never point past the last master.
    a_grant_in_range: assert property (
        @(posedge clk) disable iff (!resetn)
        grant_valid |-> (int'(grant_idx) < NUM_MASTERS)
    );

    // Nothing reaches the bridge unless a grant is held.
    a_no_idle_req: assert property (
        @(posedge clk) disable iff (!resetn)
        !grant_valid |-> !oreq.valid
    );

endmodule

// File: tb/tb_cbus_arbiter_n.sv
// Self-checking bench for cbus_arbiter_n: one 2-master round-robin instance,
// one 3-master round-robin instance and one 3-master fixed-priority instance.
// Inputs change on the falling edge; outputs are sampled 1ns later.
module tb_cbus_arbiter_n;
    import cbus_pkg::*;

    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    cbus_req_t  req2 [2];
    cbus_resp_t rsp2 [2];
    cbus_req_t  oreq2;
    cbus_resp_t oresp2;
    logic       gv2;
    logic [0:0] gi2;

    cbus_req_t  req3 [3];
    cbus_resp_t rsp3 [3];
    cbus_req_t  oreq3;
    cbus_resp_t oresp3;
    logic       gv3;
    logic [1:0] gi3;

    cbus_req_t  reqf [3];
    cbus_resp_t rspf [3];
    cbus_req_t  oreqf;
    cbus_resp_t orespf;
    logic       gvf;
    logic [1:0] gif;

    int checks = 0;
    int errors = 0;
    logic [63:0] exp_q [$];
    logic [63:0] exp_d;
    int          grant_q [$];
    int          exp_g;

    cbus_arbiter_n #(.NUM_MASTERS(2), .MODE(0)) u_rr2 (
        .clk(clk), .resetn(resetn), .ireqs(req2), .iresps(rsp2),
        .oreq(oreq2), .oresp(oresp2), .grant_valid(gv2), .grant_idx(gi2)
    );

    cbus_arbiter_n #(.NUM_MASTERS(3), .MODE(0)) u_rr3 (
        .clk(clk), .resetn(resetn), .ireqs(req3), .iresps(rsp3),
        .oreq(oreq3), .oresp(oresp3), .grant_valid(gv3), .grant_idx(gi3)
    );

    cbus_arbiter_n #(.NUM_MASTERS(3), .MODE(1)) u_fp3 (
        .clk(clk), .resetn(resetn), .ireqs(reqf), .iresps(rspf),
        .oreq(oreqf), .oresp(orespf), .grant_valid(gvf), .grant_idx(gif)
    );

    function automatic cbus_req_t mk_req(input logic wr, input logic [63:0] a, input cbus_len_t l);
        cbus_req_t r;
        r          = '0;
        r.valid    = 1'b1;
        r.is_write = wr;
        r.addr     = a;
        r.size     = 3'd3;
        r.len      = l;
        r.strobe   = wr ? 8'hff : 8'h00;
        r.data     = wr ? a ^ 64'h5555_5555_5555_5555 : 64'h0;
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Bridge model for u_rr3: returns nbeats beats to the expected owner.
    task automatic u3_serve(input int owner, input int nbeats);
        for (int b = 0; b < nbeats; b++) begin
            oresp3.ready = 1'b1;
            oresp3.last  = (b == nbeats - 1);
            oresp3.data  = 64'hA000_0000 + 64'(owner * 256 + b);
            exp_q.push_back(oresp3.data);
            #1;
            checks++;
            if (gv3 !== 1'b1 || gi3 !== 2'(owner)) begin
                errors++;
                $display("FAIL serve_grant got gv=%0b idx=%0d want gv=1 idx=%0d", gv3, gi3, owner);
            end
            exp_d = exp_q.pop_front();
            for (int j = 0; j < 3; j++) begin
                checks++;
                if (j == owner) begin
                    if (rsp3[j].ready !== 1'b1 || rsp3[j].data !== exp_d) begin
                        errors++;
                        $display("FAIL serve_fwd m%0d got rdy=%0b data=%h want rdy=1 data=%h",
                                 j, rsp3[j].ready, rsp3[j].data, exp_d);
                    end
                end else if (rsp3[j] !== '0) begin
                    errors++;
                    $display("FAIL serve_other m%0d got %h want 0", j, rsp3[j]);
                end
            end
            tick();
        end
        oresp3 = '0;
    endtask

    task automatic test_reset();
        for (int j = 0; j < 3; j++) req3[j] = mk_req(1'b0, 64'h100 * j, MLEN1);
        oresp3 = '{ready: 1'b1, last: 1'b1, data: 64'hFFFF};
        #1;
        checks++;
        if (gv2 !== 1'b0 || gv3 !== 1'b0 || gvf !== 1'b0) begin
            errors++;
            $display("FAIL reset_gv got %0b%0b%0b want 000", gv2, gv3, gvf);
        end
        checks++;
        if (oreq3 !== '0 || oreq2 !== '0 || oreqf !== '0) begin
            errors++;
            $display("FAIL reset_oreq got %h want 0", oreq3);
        end
        for (int j = 0; j < 3; j++) begin
            checks++;
            if (rsp3[j] !== '0) begin
                errors++;
                $display("FAIL reset_iresp m%0d got %h want 0", j, rsp3[j]);
            end
        end
        for (int j = 0; j < 3; j++) req3[j] = '0;
        oresp3 = '0;
    endtask

    task automatic test_single();
        req2[1] = mk_req(1'b0, 64'h8000_0040, MLEN4);
        #1;
        checks++;
        if (oreq2.valid !== 1'b0 || gv2 !== 1'b0) begin
            errors++;
            $display("FAIL single_nocomb got valid=%0b gv=%0b want 0 0", oreq2.valid, gv2);
        end
        tick();
        #1;
        checks++;
        if (gv2 !== 1'b1 || gi2 !== 1'b1) begin
            errors++;
            $display("FAIL single_grant got gv=%0b idx=%0d want 1 1", gv2, gi2);
        end
        checks++;
        if (oreq2.valid !== 1'b1 || oreq2.addr !== 64'h8000_0040 || oreq2.len !== MLEN4) begin
            errors++;
            $display("FAIL single_oreq got v=%0b addr=%h want v=1 addr=8000_0040", oreq2.valid, oreq2.addr);
        end
        for (int b = 0; b < 4; b++) begin
            oresp2.ready = 1'b1;
            oresp2.last  = (b == 3);
            oresp2.data  = 64'(b + 1) * 64'h11;
            exp_q.push_back(64'(b + 1) * 64'h11);
            #1;
            exp_d = exp_q.pop_front();
            checks++;
            if (rsp2[1].ready !== 1'b1 || rsp2[1].data !== exp_d || rsp2[1].last !== (b == 3)) begin
                errors++;
                $display("FAIL single_beat%0d got rdy=%0b last=%0b data=%h want data=%h",
                         b, rsp2[1].ready, rsp2[1].last, rsp2[1].data, exp_d);
            end
            checks++;
            if (rsp2[0] !== '0) begin
                errors++;
                $display("FAIL single_m0 got %h want 0", rsp2[0]);
            end
            tick();
        end
        // Back in IDLE: stray bridge responses must not be forwarded.
        req2[1] = '0;
        oresp2  = '{ready: 1'b1, last: 1'b1, data: 64'hDEAD};
        #1;
        checks++;
        if (gv2 !== 1'b0 || rsp2[1] !== '0 || rsp2[0] !== '0) begin
            errors++;
            $display("FAIL single_idle got gv=%0b r1=%h r0=%h want 0", gv2, rsp2[1], rsp2[0]);
        end
        oresp2 = '0;
        tick();
    endtask

    task automatic test_fairness();
        for (int j = 0; j < 3; j++) req3[j] = mk_req(1'b0, 64'h1000 + 64'h40 * j, MLEN1);
        for (int r = 0; r < 2; r++) begin
            grant_q.push_back(0);
            grant_q.push_back(1);
            grant_q.push_back(2);
        end
        tick();
        for (int n = 0; n < 6; n++) begin
            #1;
            exp_g = grant_q.pop_front();
            checks++;
            if (gv3 !== 1'b1 || gi3 !== 2'(exp_g)) begin
                errors++;
                $display("FAIL rr_order%0d got gv=%0b idx=%0d want idx=%0d", n, gv3, gi3, exp_g);
            end
            u3_serve(exp_g, 1);
            if (n == 5) begin
                for (int j = 0; j < 3; j++) req3[j] = '0;
            end
            #1;
            checks++;
            if (gv3 !== 1'b0) begin
                errors++;
                $display("FAIL rr_dead%0d got gv=%0b want 0", n, gv3);
            end
            tick();
        end
    endtask

    task automatic test_lock();
        req3[0] = mk_req(1'b1, 64'h2000, MLEN16);
        tick();
        for (int b = 0; b < 16; b++) begin
            if (b == 2) req3[1] = mk_req(1'b0, 64'h3000, MLEN1);
            if (b == 8) begin
                // Owner drops valid mid-burst: grant holds, oreq.valid follows.
                req3[0].valid = 1'b0;
                #1;
                checks++;
                if (oreq3.valid !== 1'b0 || gv3 !== 1'b1 || gi3 !== 2'd0) begin
                    errors++;
                    $display("FAIL lock_drop got v=%0b gv=%0b idx=%0d want 0 1 0", oreq3.valid, gv3, gi3);
                end
                tick();
                req3[0].valid = 1'b1;
            end
            oresp3.ready = 1'b1;
            oresp3.last  = (b == 15);
            oresp3.data  = 64'hB000 + 64'(b);
            exp_q.push_back(64'hB000 + 64'(b));
            #1;
            exp_d = exp_q.pop_front();
            checks++;
            if (gi3 !== 2'd0 || oreq3.is_write !== 1'b1 || rsp3[0].data !== exp_d || rsp3[1] !== '0) begin
                errors++;
                $display("FAIL lock_beat%0d got idx=%0d wr=%0b data=%h r1=%h want idx=0 wr=1 data=%h",
                         b, gi3, oreq3.is_write, rsp3[0].data, rsp3[1], exp_d);
            end
            tick();
        end
        oresp3  = '0;
        req3[0] = '0;
        #1;
        checks++;
        if (gv3 !== 1'b0) begin
            errors++;
            $display("FAIL lock_idle got gv=%0b want 0", gv3);
        end
        tick();
        #1;
        checks++;
        if (gv3 !== 1'b1 || gi3 !== 2'd1) begin
            errors++;
            $display("FAIL lock_next got gv=%0b idx=%0d want 1 1", gv3, gi3);
        end
        u3_serve(1, 1);
        req3[1] = '0;
        tick();
    endtask

    task automatic test_wrap();
        // rr_ptr is 2 here; only master 0 requests.
        req3[0] = mk_req(1'b0, 64'h4000, MLEN2);
        tick();
        #1;
        checks++;
        if (gv3 !== 1'b1 || gi3 !== 2'd0) begin
            errors++;
            $display("FAIL wrap_grant got gv=%0b idx=%0d want 1 0", gv3, gi3);
        end
        u3_serve(0, 2);
        req3[0] = '0;
        tick();
        // rr_ptr must now be 1: with all three requesting, master 1 wins.
        for (int j = 0; j < 3; j++) req3[j] = mk_req(1'b0, 64'h5000 + 64'h40 * j, MLEN1);
        tick();
        #1;
        checks++;
        if (gv3 !== 1'b1 || gi3 !== 2'd1) begin
            errors++;
            $display("FAIL wrap_ptr got gv=%0b idx=%0d want 1 1", gv3, gi3);
        end
        u3_serve(1, 1);
        for (int j = 0; j < 3; j++) req3[j] = '0;
        tick();
    endtask

    task automatic test_fixed_priority();
        reqf[0] = mk_req(1'b0, 64'h6000, MLEN1);
        reqf[2] = mk_req(1'b0, 64'h6080, MLEN1);
        tick();
        for (int n = 0; n < 4; n++) begin
            #1;
            checks++;
            if (gvf !== 1'b1 || gif !== 2'd0) begin
                errors++;
                $display("FAIL fp_grant%0d got gv=%0b idx=%0d want 1 0", n, gvf, gif);
            end
            orespf = '{ready: 1'b1, last: 1'b1, data: 64'hC000 + 64'(n)};
            exp_q.push_back(64'hC000 + 64'(n));
            #1;
            exp_d = exp_q.pop_front();
            checks++;
            if (rspf[0].data !== exp_d || rspf[0].ready !== 1'b1 || rspf[2] !== '0) begin
                errors++;
                $display("FAIL fp_data%0d got %h r2=%h want %h", n, rspf[0].data, rspf[2], exp_d);
            end
            tick();
            orespf = '0;
            if (n == 3) reqf[0] = '0;
            tick();
        end
        #1;
        checks++;
        if (gvf !== 1'b1 || gif !== 2'd2) begin
            errors++;
            $display("FAIL fp_low got gv=%0b idx=%0d want 1 2", gvf, gif);
        end
        orespf = '{ready: 1'b1, last: 1'b1, data: 64'hC0FF};
        tick();
        orespf  = '0;
        reqf[2] = '0;
        tick();
    endtask

    task automatic test_reset_mid_burst();
        req3[2] = mk_req(1'b0, 64'h7000, MLEN8);
        tick();
        #1;
        checks++;
        if (gv3 !== 1'b1 || gi3 !== 2'd2) begin
            errors++;
            $display("FAIL rst_pre got gv=%0b idx=%0d want 1 2", gv3, gi3);
        end
        oresp3 = '{ready: 1'b1, last: 1'b0, data: 64'hD001};
        tick();
        oresp3 = '{ready: 1'b1, last: 1'b0, data: 64'hD002};
        #1;
        resetn = 1'b0;
        #1;
        checks++;
        if (oreq3.valid !== 1'b0 || gv3 !== 1'b0) begin
            errors++;
            $display("FAIL rst_drop got v=%0b gv=%0b want 0 0", oreq3.valid, gv3);
        end
        for (int j = 0; j < 3; j++) begin
            checks++;
            if (rsp3[j] !== '0) begin
                errors++;
                $display("FAIL rst_iresp m%0d got %h want 0", j, rsp3[j]);
            end
        end
        req3[2] = '0;
        oresp3  = '0;
        tick();
        resetn = 1'b1;
        tick();
        // rr_ptr must be back at 0: master 0 wins over 1 and 2.
        for (int j = 0; j < 3; j++) req3[j] = mk_req(1'b0, 64'h8000 + 64'h40 * j, MLEN1);
        #1;
        checks++;
        if (gv3 !== 1'b0) begin
            errors++;
            $display("FAIL rst_lat got gv=%0b want 0", gv3);
        end
        tick();
        #1;
        checks++;
        if (gv3 !== 1'b1 || gi3 !== 2'd0) begin
            errors++;
            $display("FAIL rst_regrant got gv=%0b idx=%0d want 1 0", gv3, gi3);
        end
        u3_serve(0, 1);
        for (int j = 0; j < 3; j++) req3[j] = '0;
        tick();
    endtask

    initial begin
        resetn = 1'b0;
        for (int j = 0; j < 2; j++) req2[j] = '0;
        for (int j = 0; j < 3; j++) begin
            req3[j] = '0;
            reqf[j] = '0;
        end
        oresp2 = '0;
        oresp3 = '0;
        orespf = '0;
        @(negedge clk);
        @(negedge clk);
        test_reset();
        resetn = 1'b1;
        tick();
        test_single();
        test_fairness();
        test_lock();
        test_wrap();
        test_fixed_priority();
        test_reset_mid_burst();
        checks++;
        if (exp_q.size() != 0 || grant_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_left got %0d/%0d want 0/0", exp_q.size(), grant_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule
